// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU: grant, execute, hold response.
// Optional round-robin fairness when ALU_ARB_RR_EN is defined; otherwise requester 0 has priority.
module alu_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_op,
    output logic [1:0]       resp_valid,
    input  logic [1:0]       resp_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_zero,
    output logic             resp_err,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             busy
);

    localparam int unsigned OP_W = 4;
    localparam logic [OP_W-1:0] OP_AND = 4'b0000;
    localparam logic [OP_W-1:0] OP_OR  = 4'b0001;
    localparam logic [OP_W-1:0] OP_ADD = 4'b0010;
    localparam logic [OP_W-1:0] OP_SUB = 4'b0110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e              state_q;
    logic                owner_q;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;
    logic [OP_W-1:0]     op_q;
    logic [1:0]          resp_valid_q;
    logic [WIDTH-1:0]    resp_result_q;
    logic                resp_zero_q;
    logic                resp_err_q;
    logic                busy_q;
`ifdef ALU_ARB_RR_EN
    logic                last_q;
`endif

    logic                grant_idx_c;
    logic [1:0]          req_ready_c;
    logic                accept_c;
    logic                op_ok_c;

    // Grant selection; only meaningful when at least one request is valid.
    always_comb begin
        grant_idx_c = 1'b0;
`ifdef ALU_ARB_RR_EN
        if (req_valid == 2'b11) begin
            grant_idx_c = ~last_q;
        end else begin
            grant_idx_c = req_valid[1];
        end
`else
        grant_idx_c = ~req_valid[0];
`endif
    end

    // Ready is combinational so a requester sees its grant in the same cycle it asks.
    always_comb begin
        req_ready_c = 2'b00;
        if (rst_n && (state_q == ST_IDLE) && (req_valid != 2'b00)) begin
            req_ready_c = grant_idx_c ? 2'b10 : 2'b01;
        end
    end

    assign accept_c = |(req_valid & req_ready_c);

    always_comb begin
        op_ok_c = 1'b0;
        case (op_q)
            OP_AND, OP_OR, OP_ADD, OP_SUB: op_ok_c = 1'b1;
            default:                       op_ok_c = 1'b0;
        endcase
    end

    // Control FSM and all registered state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            owner_q       <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            op_q          <= '0;
            resp_valid_q  <= 2'b00;
            resp_result_q <= '0;
            resp_zero_q   <= 1'b0;
            resp_err_q    <= 1'b0;
            busy_q        <= 1'b0;
`ifdef ALU_ARB_RR_EN
            last_q        <= 1'b1;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_c) begin
                        owner_q <= grant_idx_c;
                        a_q     <= grant_idx_c ? req1_a  : req0_a;
                        b_q     <= grant_idx_c ? req1_b  : req0_b;
                        op_q    <= grant_idx_c ? req1_op : req0_op;
                        busy_q  <= 1'b1;
                        state_q <= ST_EXEC;
`ifdef ALU_ARB_RR_EN
                        last_q  <= grant_idx_c;
`endif
                    end
                end
                ST_EXEC: begin
                    // Unsupported codes force a canned error response regardless of ALU output.
                    if (op_ok_c) begin
                        resp_result_q <= alu_result;
                        resp_zero_q   <= alu_zero;
                        resp_err_q    <= 1'b0;
                    end else begin
                        resp_result_q <= '0;
                        resp_zero_q   <= 1'b1;
                        resp_err_q    <= 1'b1;
                    end
                    resp_valid_q <= owner_q ? 2'b10 : 2'b01;
                    state_q      <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready[owner_q]) begin
                        resp_valid_q <= 2'b00;
                        busy_q       <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    resp_valid_q <= 2'b00;
                    busy_q       <= 1'b0;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_c;
    assign resp_valid  = resp_valid_q;
    assign resp_result = resp_result_q;
    assign resp_zero   = resp_zero_q;
    assign resp_err    = resp_err_q;
    assign busy        = busy_q;

    // Shared ALU sees the latched operation only while executing.
    assign alu_a    = (state_q == ST_EXEC) ? a_q  : '0;
    assign alu_b    = (state_q == ST_EXEC) ? b_q  : '0;
    assign alu_ctrl = (state_q == ST_EXEC) ? op_q : '0;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 req_valid  in  2  bit i = requester i presents an operation.
REQ-005 req_ready  out  2  bit i = requester i's operation accepted this cycle.
REQ-006 req0_a, req0_b  in  WIDTH each  requester 0 operands.
REQ-007 req0_op  in  4  requester 0 ALU control code.
REQ-008 req1_a, req1_b  in  WIDTH each  requester 1 operands.
REQ-009 req1_op  in  4  requester 1 ALU control code.
REQ-010 resp_valid  out  2  bit i = response pending for requester i.
REQ-011 resp_ready  in  2  bit i = requester i consumes its response.
REQ-012 resp_result  out  WIDTH  result of the completed operation.
REQ-013 resp_zero  out  1  zero flag of the completed operation.
REQ-014 resp_err  out  1  completed operation used an unsupported code.
REQ-015 alu_a, alu_b  out  WIDTH each  operands driven to the shared ALU.
REQ-016 alu_ctrl  out  4  control code driven to the shared ALU.
REQ-017 alu_result  in  WIDTH  ALU result, combinational from alu_a/alu_b/alu_ctrl.
REQ-018 alu_zero  in  1  ALU zero flag.
REQ-019 busy  out  1  high in every state except IDLE.

Function
REQ-020 FSM states SHALL be IDLE, EXEC, RESP; one operation in flight at a time.
REQ-021 IDLE: req_ready SHALL be one-hot on the granted requester when any req_valid is high, else 0; req_ready SHALL be 0 in EXEC and RESP.
REQ-022 Accept (req_valid[i] & req_ready[i]) SHALL latch that requester's a, b, op and owner index, and move IDLE->EXEC.
REQ-023 EXEC: alu_a/alu_b/alu_ctrl SHALL carry the latched values; at the clock edge, alu_result/alu_zero SHALL be captured into resp_result/resp_zero, and EXEC->RESP.
REQ-024 Outside EXEC, alu_a, alu_b, alu_ctrl SHALL be 0.
REQ-025 Supported codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB; any other code SHALL give resp_err=1, resp_result=0, resp_zero=1, with ALU output ignored.
REQ-026 RESP: resp_valid SHALL be one-hot on the owner; resp_result/resp_zero/resp_err SHALL hold stable until resp_ready[owner]=1, then RESP->IDLE.
REQ-027 resp_ready on the non-owner bit SHALL be ignored.
REQ-028 Latency: accept at edge N, resp_valid high after edge N+1; minimum issue interval 3 cycles.
REQ-029 req_valid deasserted before acceptance SHALL cancel nothing; no state change occurs.
REQ-030 Arithmetic SHALL wrap modulo 2^WIDTH; no overflow flag.

Reset
REQ-031 While rst_n=0 at a rising edge: state SHALL be IDLE, resp_valid=0, resp_result=0, resp_zero=0, resp_err=0, latched operands/op=0, round-robin pointer=requester 1 last served.
REQ-032 Reset mid-operation (EXEC or RESP) SHALL discard the in-flight operation; no response is delivered.
REQ-033 req_ready SHALL be 0 during any cycle with rst_n=0.

Configuration
REQ-034 Macro ALU_ARB_RR_EN defined: with both req_valid high in IDLE, grant SHALL go to the requester not served last; the pointer updates on each accept.
REQ-035 ALU_ARB_RR_EN undefined: requester 0 SHALL always win when both valid; the pointer is absent.
REQ-036 A single valid requester SHALL be granted immediately in both configurations.

Verification
REQ-037 Req0 ADD a=5,b=7 -> req_ready=01 at accept, resp_valid=01 two edges later, resp_result=12, resp_zero=0, resp_err=0.
REQ-038 Req1 SUB a=9,b=9 -> resp_valid=10, resp_result=0, resp_zero=1; ADD 0xFFFFFFFF+1 -> result 0, zero=1.
REQ-039 Both valid continuously, ops AND 0xF0F0,0x0FF0 / OR 0x1,0x2 -> with ALU_ARB_RR_EN grants alternate 0,1,0,1; without it grants stay 0 until req0 drops.
REQ-040 Op code 0101 -> resp_err=1, resp_result=0, resp_zero=1.
REQ-041 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid and data stable, req_ready=00, busy=1; then resp_ready=1 -> IDLE next edge.
REQ-042 rst_n=0 for one edge during EXEC -> IDLE, resp_valid=00, no response for the aborted operation.
